gpr_file_mp: RTL and testbench

- Parametrised multi-port general-purpose register file; successor to the single-write, two-read GPR.
- Adds configurable data width and depth, NRD read ports, and two write ports with defined collision priority.
- Adds optional same-cycle write-to-read bypass and a pending-write scoreboard for hazard detection.
- Sits between decode (read, issue) and writeback (write) of the pipelined MIPS core.
- Keeps the hard-wired zero register and the overflow-flag sticky bit.

---
 rtl/gpr_pkg.sv | 43 ++++
 rtl/gpr_scoreboard.sv | 60 ++++++
 rtl/gpr_file_mp.sv | 122 ++++++++++++
 tb/tb_gpr_file_mp.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared constants, read-source encoding and bus-slicing helpers for the
// multi-port general-purpose register file.
package gpr_pkg;

    localparam int GPR_DATA_W  = 32;
    localparam int GPR_NREGS   = 32;
    localparam int GPR_ADDR_W  = 5;
    localparam int ZERO_REG    = 0;
    localparam int GPR_OVF_REG = 30;
    localparam int GPR_OVF_BIT = 0;

    // Where a read port takes its value from, highest priority first.
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_WR1   = 2'd1,
        SRC_WR0   = 2'd2,
        SRC_ARRAY = 2'd3
    } rd_src_e;

    // Low bit of port 'port' inside a flattened bus of 'width'-bit fields.
    function automatic int unsigned slice_lo(input int unsigned port,
                                             input int unsigned width);
        return port * width;
    endfunction

    // The younger write port (wr1) outranks wr0 when both match.
    function automatic rd_src_e pick_src(input logic is_zero,
                                         input logic hit1,
                                         input logic hit0);
        rd_src_e src;
        if (is_zero) begin
            src = SRC_ZERO;
        end else if (hit1) begin
            src = SRC_WR1;
        end else if (hit0) begin
            src = SRC_WR0;
        end else begin
            src = SRC_ARRAY;
        end
        return src;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one bit per register, cleared by writeback and
// set by issue, with NRD combinational lookup ports.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int NREGS  = GPR_NREGS,
    parameter int ADDR_W = GPR_ADDR_W,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr0_en,
    input  logic [ADDR_W-1:0]     clr0_addr,
    input  logic                  clr1_en,
    input  logic [ADDR_W-1:0]     clr1_addr,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic [NRD*ADDR_W-1:0] look_addr,
    output logic [NRD-1:0]        look_busy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_next;

    // Clears come first so a same-cycle issue to the same index keeps it
    // pending: the newly issued producer now owns that register.
    always_comb begin
        pend_next = pend;
        if (clr0_en && (clr0_addr != ZERO_ADDR)) begin
            pend_next[clr0_addr] = 1'b0;
        end
        if (clr1_en && (clr1_addr != ZERO_ADDR)) begin
            pend_next[clr1_addr] = 1'b0;
        end
        if (set_en && (set_addr != ZERO_ADDR)) begin
            pend_next[set_addr] = 1'b1;
        end
        pend_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (en) begin
            pend <= pend_next;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_look
        localparam int unsigned A_LO = slice_lo(k, ADDR_W);
        logic [ADDR_W-1:0] addr;

        assign addr         = look_addr[A_LO +: ADDR_W];
        assign look_busy[k] = pend[addr];
    end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: NRD combinational read ports with optional write
// bypass, two prioritised write ports, sticky overflow flag and scoreboard.
module gpr_file_mp
    import gpr_pkg::*;
#(
    parameter int DATA_W  = GPR_DATA_W,
    parameter int NREGS   = GPR_NREGS,
    parameter int ADDR_W  = GPR_ADDR_W,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int OVF_REG = GPR_OVF_REG,
    parameter int OVF_BIT = GPR_OVF_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr0_en,
    input  logic [ADDR_W-1:0]     wr0_addr,
    input  logic [DATA_W-1:0]     wr0_data,
    input  logic                  wr1_en,
    input  logic [ADDR_W-1:0]     wr1_addr,
    input  logic [DATA_W-1:0]     wr1_data,
    input  logic                  set_overflow_bit,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] OVF_ADDR  = ADDR_W'(OVF_REG);
    localparam logic              USE_BYP   = (BYPASS != 0);

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0][DATA_W-1:0] next_regs;
    logic                         wr0_ok;
    logic                         wr1_ok;
    logic                         ovf_ok;
    logic [NRD-1:0]               busy_raw;

    // Qualified write/flag strobes; rst also masks them so that nothing
    // forwards or commits while the file is being cleared.
    assign wr0_ok = en && !rst && wr0_en && (wr0_addr != ZERO_ADDR);
    assign wr1_ok = en && !rst && wr1_en && (wr1_addr != ZERO_ADDR);
    assign ovf_ok = en && !rst && set_overflow_bit;

    // wr1 is applied after wr0 so it wins a collision, and the flag is
    // forced last so a same-cycle write to OVF_REG can never drop it.
    always_comb begin
        next_regs = regs;
        if (wr0_ok) begin
            next_regs[wr0_addr] = wr0_data;
        end
        if (wr1_ok) begin
            next_regs[wr1_addr] = wr1_data;
        end
        if (ovf_ok) begin
            next_regs[OVF_ADDR][OVF_BIT] = 1'b1;
        end
        next_regs[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (en) begin
            regs <= next_regs;
        end
    end

    gpr_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr0_en   (wr0_en),
        .clr0_addr (wr0_addr),
        .clr1_en   (wr1_en),
        .clr1_addr (wr1_addr),
        .set_en    (iss_en),
        .set_addr  (iss_addr),
        .look_addr (rd_addr),
        .look_busy (busy_raw)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        localparam int unsigned A_LO = slice_lo(k, ADDR_W);
        localparam int unsigned D_LO = slice_lo(k, DATA_W);

        logic [ADDR_W-1:0] addr;
        logic              hit0;
        logic              hit1;
        rd_src_e           src;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[A_LO +: ADDR_W];
        assign hit0 = USE_BYP && wr0_ok && (wr0_addr == addr);
        assign hit1 = USE_BYP && wr1_ok && (wr1_addr == addr);
        assign src  = pick_src(addr == ZERO_ADDR, hit1, hit0);

        always_comb begin
            case (src)
                SRC_ZERO:  data = '0;
                SRC_WR1:   data = wr1_data;
                SRC_WR0:   data = wr0_data;
                default:   data = regs[addr];
            endcase
            if (USE_BYP && ovf_ok && (src != SRC_ZERO) && (addr == OVF_ADDR)) begin
                data[OVF_BIT] = 1'b1;
            end
        end

        assign rd_data[D_LO +: DATA_W] = data;
        // A write landing this cycle resolves the hazard for the bypassed reader.
        assign rd_busy[k] = busy_raw[k] && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: a BYPASS=1 and a BYPASS=0 copy share stimulus and
// are compared against an array-based program-order model.
module tb_gpr_file_mp;

    logic        clk;
    logic        rst;
    logic        en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_b1;
    logic [63:0] rd_data_b0;
    logic [1:0]  rd_busy_b1;
    logic [1:0]  rd_busy_b0;
    logic        wr0_en;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic        wr1_en;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic        set_overflow_bit;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [31:0] mem  [32];
    bit          pend [32];
    int          total;
    int          bad;

    gpr_file_mp #(.BYPASS(1)) dut_b1 (
        .clk (clk), .rst (rst), .en (en),
        .rd_addr (rd_addr), .rd_data (rd_data_b1), .rd_busy (rd_busy_b1),
        .wr0_en (wr0_en), .wr0_addr (wr0_addr), .wr0_data (wr0_data),
        .wr1_en (wr1_en), .wr1_addr (wr1_addr), .wr1_data (wr1_data),
        .set_overflow_bit (set_overflow_bit),
        .iss_en (iss_en), .iss_addr (iss_addr)
    );

    gpr_file_mp #(.BYPASS(0)) dut_b0 (
        .clk (clk), .rst (rst), .en (en),
        .rd_addr (rd_addr), .rd_data (rd_data_b0), .rd_busy (rd_busy_b0),
        .wr0_en (wr0_en), .wr0_addr (wr0_addr), .wr0_data (wr0_data),
        .wr1_en (wr1_en), .wr1_addr (wr1_addr), .wr1_data (wr1_data),
        .set_overflow_bit (set_overflow_bit),
        .iss_en (iss_en), .iss_addr (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void modelClear();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
    endfunction

    // Effect of one enabled cycle in program order: wr0, then wr1, then the flag.
    function automatic void modelCommit();
        if (en) begin
            if (wr0_en && wr0_addr != 0) begin
                mem[wr0_addr]  = wr0_data;
                pend[wr0_addr] = 1'b0;
            end
            if (wr1_en && wr1_addr != 0) begin
                mem[wr1_addr]  = wr1_data;
                pend[wr1_addr] = 1'b0;
            end
            if (set_overflow_bit) mem[30][0] = 1'b1;
            if (iss_en && iss_addr != 0) pend[iss_addr] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = mem[a];
        if (byp && en && !rst) begin
            if (wr1_en && wr1_addr == a) v = wr1_data;
            else if (wr0_en && wr0_addr == a) v = wr0_data;
            if (set_overflow_bit && a == 30) v[0] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic expBusy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && en && !rst && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)))
            return 1'b0;
        return pend[a];
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [4:0] a;
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            check32($sformatf("b1_data%0d_r%0d", k, a), rd_data_b1[k*32 +: 32], expRead(a, 1'b1));
            check32($sformatf("b0_data%0d_r%0d", k, a), rd_data_b0[k*32 +: 32], expRead(a, 1'b0));
            check1($sformatf("b1_busy%0d_r%0d", k, a), rd_busy_b1[k], expBusy(a, 1'b1));
            check1($sformatf("b0_busy%0d_r%0d", k, a), rd_busy_b0[k], expBusy(a, 1'b0));
        end
    endtask

    task automatic setIdle(input logic [4:0] a0, input logic [4:0] a1);
        en               = 1'b1;
        wr0_en           = 1'b0;
        wr0_addr         = '0;
        wr0_data         = '0;
        wr1_en           = 1'b0;
        wr1_addr         = '0;
        wr1_data         = '0;
        set_overflow_bit = 1'b0;
        iss_en           = 1'b0;
        iss_addr         = '0;
        rd_addr          = {a1, a0};
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic applyStimulus();
        #2;
        checkOutput();
        @(posedge clk);
        modelCommit();
        @(negedge clk);
    endtask

    function automatic logic [4:0] randAddr();
        case ($urandom_range(0, 3))
            0:       return 5'($urandom_range(0, 3));
            1:       return 5'd30;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        modelClear();
        rst = 1'b1;
        setIdle(5'd5, 5'd0);
        @(negedge clk);
        #2;
        checkOutput();
        check32("reset_r5", rd_data_b1[31:0], 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-cycle wipes a committed value at once.
        setIdle(5'd5, 5'd5);
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd5;
        applyStimulus();
        setIdle(5'd5, 5'd0);
        #2;
        check32("r5_written", rd_data_b1[31:0], 32'hDEADBEEF);
        rst = 1'b1;
        modelClear();
        #1;
        check32("r5_after_rst", rd_data_b1[31:0], 32'h0);
        check1("r5_busy_after_rst", rd_busy_b1[0], 1'b0);
        checkOutput();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Writes and issues to r0 have no effect.
        setIdle(5'd0, 5'd0);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h12345678;
        iss_en = 1'b1; iss_addr = 5'd0;
        #2;
        check32("r0_write_cycle", rd_data_b1[31:0], 32'h0);
        applyStimulus();
        setIdle(5'd0, 5'd0);
        #2;
        check32("r0_next_cycle", rd_data_b1[31:0], 32'h0);
        check1("r0_not_busy", rd_busy_b1[0], 1'b0);
        applyStimulus();

        // Dual-write collision: wr1 wins.
        setIdle(5'd7, 5'd7);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2222;
        #2;
        check32("collide_bypass", rd_data_b1[31:0], 32'h2222);
        applyStimulus();
        setIdle(5'd7, 5'd7);
        #2;
        check32("collide_b1", rd_data_b1[63:32], 32'h2222);
        check32("collide_b0", rd_data_b0[31:0], 32'h2222);
        applyStimulus();

        // Overflow flag merged into a same-cycle write, then set alone.
        setIdle(5'd30, 5'd0);
        wr0_en = 1'b1; wr0_addr = 5'd30; wr0_data = 32'hF0;
        set_overflow_bit = 1'b1;
        applyStimulus();
        setIdle(5'd30, 5'd0);
        #2;
        check32("ovf_merge", rd_data_b0[31:0], 32'hF1);
        applyStimulus();
        setIdle(5'd30, 5'd0);
        wr1_en = 1'b1; wr1_addr = 5'd30; wr1_data = 32'h10;
        applyStimulus();
        setIdle(5'd30, 5'd0);
        set_overflow_bit = 1'b1;
        applyStimulus();
        setIdle(5'd30, 5'd30);
        #2;
        check32("ovf_alone", rd_data_b0[31:0], 32'h11);
        applyStimulus();

        // Scoreboard: issue, write+issue, write alone.
        setIdle(5'd9, 5'd0);
        iss_en = 1'b1; iss_addr = 5'd9;
        applyStimulus();
        setIdle(5'd9, 5'd0);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        iss_en = 1'b1; iss_addr = 5'd9;
        #2;
        check1("sb_issued", rd_busy_b0[0], 1'b1);
        applyStimulus();
        setIdle(5'd9, 5'd0);
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h9A;
        #2;
        check1("sb_reissued", rd_busy_b0[0], 1'b1);
        check1("sb_bypass_clear", rd_busy_b1[0], 1'b0);
        applyStimulus();
        setIdle(5'd9, 5'd9);
        #2;
        check1("sb_cleared", rd_busy_b0[0], 1'b0);
        applyStimulus();

        // Stall: en=0 freezes state and disables forwarding.
        setIdle(5'd3, 5'd0);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h55;
        applyStimulus();
        setIdle(5'd3, 5'd0);
        en = 1'b0;
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAB;
        iss_en = 1'b1; iss_addr = 5'd3;
        #2;
        check32("stall_no_bypass", rd_data_b1[31:0], 32'h55);
        applyStimulus();
        setIdle(5'd3, 5'd0);
        #2;
        check32("stall_kept", rd_data_b1[31:0], 32'h55);
        check1("stall_not_busy", rd_busy_b1[0], 1'b0);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAB;
        #1;
        check32("enabled_bypass", rd_data_b1[31:0], 32'hAB);
        check32("enabled_nobypass", rd_data_b0[31:0], 32'h55);
        applyStimulus();

        // Randomised traffic with collision-prone addresses.
        for (int n = 0; n < 400; n++) begin
            en               = ($urandom_range(0, 9) != 0);
            wr0_en           = 1'($urandom_range(0, 1));
            wr0_addr         = randAddr();
            wr0_data         = $urandom;
            wr1_en           = 1'($urandom_range(0, 1));
            wr1_addr         = randAddr();
            wr1_data         = $urandom;
            set_overflow_bit = ($urandom_range(0, 4) == 0);
            iss_en           = 1'($urandom_range(0, 1));
            iss_addr         = randAddr();
            rd_addr          = {randAddr(), randAddr()};
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
